muldiv_unit: RTL and testbench

Multiply/divide unit for the five-stage MIPS pipeline. It owns the HI/LO registers, accepts mult/multu/div/divu/mthi/mtlo from the E stage, and drives `Busy` back to the D-stage hazard logic. That hazard logic stalls any mult/div/mfhi/mflo/mthi/mtlo in D while `Busy || Start` is high. Results commit to HI/LO only after a fixed per-operation latency.

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Purpose : MIPS multiply/divide unit owning HI/LO; accepts mult/multu/div/divu and mthi/mtlo.
// Latency : MULT_CYCLES / DIV_CYCLES busy cycles after Start; HI/LO update on the edge that ends Busy.
// Backpr. : Busy (registered) tells the D-stage hazard logic to hold; Start/MT_we while Busy are dropped.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   A, B             - rs / rt operands (A is also the mthi/mtlo source)
//   Start, MDOp      - begin op: 00 mult, 01 multu, 10 div, 11 divu
//   MT_we, MT_sel    - mthi (MT_sel=0) / mtlo (MT_sel=1) write request
//   Req              - M-stage flush; blocks new Start/MT_we this cycle
//   Busy, HI, LO     - operation in progress, architectural HI/LO
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic        MT_we,
  input  logic        MT_sel,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             wr_q, wr_d;

  // ---------------- arithmetic (evaluated in the Start cycle) ----------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               a_neg, b_neg, div_zero;
  logic        [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Division is done on magnitudes so INT_MIN / -1 falls out naturally as
  // 0x80000000 with remainder 0, and no host-side overflow can occur.
  assign a_neg    = ~MDOp[0] & A[31];
  assign b_neg    = ~MDOp[0] & B[31];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;
  assign div_zero = (B == 32'd0);
  // Divisor forced to 1 on divide-by-zero; the result is never committed anyway.
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem      = a_neg ? -r_mag : r_mag;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (Start && !Req) begin
          state_d = RUN;
          if (MDOp[1]) begin
            cnt_d    = CNT_W'(DIV_CYCLES);
            res_hi_d = rem;
            res_lo_d = quo;
            wr_d     = !div_zero;
          end else begin
            cnt_d                = CNT_W'(MULT_CYCLES);
            {res_hi_d, res_lo_d} = MDOp[0] ? prod_u : $unsigned(prod_s);
            wr_d                 = 1'b1;
          end
        end else if (MT_we && !Req) begin
          // Start has priority; MT_we only reaches here when Start is absent.
          if (MT_sel) lo_d = A;
          else        hi_d = A;
        end
      end
      RUN: begin
        // Req is deliberately ignored here: the running op is already past M.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: mult/multu/div/divu results and timing,
// divide edge cases, ignored requests (Busy, Req, Start+MT_we) and mid-run reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic [1:0]  MDOp;
  logic        MT_we;
  logic        MT_sel;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .Start  (Start),
    .MDOp   (MDOp),
    .MT_we  (MT_we),
    .MT_sel (MT_sel),
    .Req    (Req),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each call lands 1 time unit after a rising edge: inputs change and
  // outputs are sampled there, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues Start in the current cycle t, checks Busy over t..t+n+1 and that
  // HI/LO still hold old values in cycle t+n. Returns in cycle t+n+1.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo);
    A = a; B = b; MDOp = op; Start = 1'b1;
    chk({tag, "_busy_t0"}, {31'd0, Busy}, 32'd0);
    tick();
    Start = 1'b0; MT_we = 1'b0;
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, Busy}, 32'd1);
      if (i == n) begin
        chk({tag, "_hi_hold"}, HI, old_hi);
        chk({tag, "_lo_hold"}, LO, old_lo);
      end
      tick();
    end
    chk({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; Start = 1'b0; MDOp = 2'b00;
    MT_we = 1'b0; MT_sel = 1'b0; Req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);

    // Signed mult -3 * 5 = -15
    run_op("mult", 32'hFFFF_FFFD, 32'd5, 2'b00, 5, 32'h0, 32'h0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFF1);

    // Back-to-back multu, then div in the first non-busy cycle
    run_op("multu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);
    run_op("div", 32'hFFFF_FFF9, 32'd2, 2'b10, 10, 32'hFFFF_FFFE, 32'h0000_0001);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // mthi / mtlo preload
    MT_we = 1'b1; MT_sel = 1'b0; A = 32'h1111_1111;
    tick();
    MT_we = 1'b0;
    chk("mthi", HI, 32'h1111_1111);
    MT_we = 1'b1; MT_sel = 1'b1; A = 32'h2222_2222;
    tick();
    MT_we = 1'b0;
    chk("mtlo", LO, 32'h2222_2222);

    // divu by zero: full busy time, HI/LO untouched
    run_op("divu0", 32'd7, 32'd0, 2'b11, 10, 32'h1111_1111, 32'h2222_2222);
    chk("divu0_hi", HI, 32'h1111_1111);
    chk("divu0_lo", LO, 32'h2222_2222);

    // INT_MIN / -1
    run_op("divmin", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 10, 32'h1111_1111, 32'h2222_2222);
    chk("divmin_lo", LO, 32'h8000_0000);
    chk("divmin_hi", HI, 32'h0);

    // Start and MT_we while busy are ignored: mult 3*4 = 12
    A = 32'd3; B = 32'd4; MDOp = 2'b00; Start = 1'b1;
    tick();                                       // cycle 1
    Start = 1'b0;
    tick();                                       // cycle 2
    tick();                                       // cycle 3
    A = 32'd5; B = 32'd5; Start = 1'b1;
    chk("ign_busy_c3", {31'd0, Busy}, 32'd1);
    tick();                                       // cycle 4
    Start = 1'b0; MT_we = 1'b1; MT_sel = 1'b0; A = 32'hDEAD_BEEF;
    chk("ign_busy_c4", {31'd0, Busy}, 32'd1);
    tick();                                       // cycle 5
    MT_we = 1'b0;
    chk("ign_busy_c5", {31'd0, Busy}, 32'd1);
    chk("ign_hi_c5", HI, 32'h0);
    chk("ign_lo_c5", LO, 32'h8000_0000);
    tick();                                       // cycle 6
    chk("ign_busy_c6", {31'd0, Busy}, 32'd0);
    chk("ign_hi_c6", HI, 32'h0);
    chk("ign_lo_c6", LO, 32'h0000_000C);
    tick();                                       // cycle 7
    chk("ign_busy_c7", {31'd0, Busy}, 32'd0);
    chk("ign_mt_hi", HI, 32'h0);

    // Start with Req: no operation starts
    A = 32'd2; B = 32'd3; MDOp = 2'b00; Start = 1'b1; Req = 1'b1;
    tick();
    Start = 1'b0; Req = 1'b0;
    chk("req_start_busy1", {31'd0, Busy}, 32'd0);
    tick();
    chk("req_start_busy2", {31'd0, Busy}, 32'd0);
    chk("req_start_hi", HI, 32'h0);
    chk("req_start_lo", LO, 32'h0000_000C);

    // MT_we with Req: dropped
    MT_we = 1'b1; MT_sel = 1'b1; A = 32'hAAAA_AAAA; Req = 1'b1;
    tick();
    MT_we = 1'b0; Req = 1'b0;
    chk("req_mt_lo", LO, 32'h0000_000C);

    // Start and MT_we together: Start wins (mult 2*3), mthi of A=2 dropped
    MT_we = 1'b1; MT_sel = 1'b0;
    run_op("combo", 32'd2, 32'd3, 2'b00, 5, 32'h0, 32'h0000_000C);
    chk("combo_hi", HI, 32'h0);
    chk("combo_lo", LO, 32'h0000_0006);

    // Reset mid-run: mult 7*6 must never commit
    A = 32'd7; B = 32'd6; MDOp = 2'b00; Start = 1'b1;
    tick();                                       // cycle 1
    Start = 1'b0;
    tick();                                       // cycle 2
    tick();                                       // cycle 3
    reset = 1'b1;
    tick();                                       // cycle 4
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'h0);
    chk("rst_mid_lo", LO, 32'h0);
    for (int i = 0; i < 12; i++) tick();
    chk("rst_late_busy", {31'd0, Busy}, 32'd0);
    chk("rst_late_hi", HI, 32'h0);
    chk("rst_late_lo", LO, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
